// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM encoding, default geometry and parity helper.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned PAR_W           = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Even parity bit of a (zero-extended) data word.
  function automatic logic parity_even(input logic [PAR_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver_ash.sv
// UART receiver: start, DATA_BITS LSB first, even parity, stop; oversampled on baud_tick.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote over the last three ticks.
module uart_receiver_ash
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] RX_Data,
  output logic                 rx_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] MID_START = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] MID_BIT   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  logic rxd_s;
  logic sample;

  uart_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 brk_q, brk_d;
  logic                 deliver;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (RXD),
    .q     (rxd_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // The two previous tick samples plus the current one form the vote window.
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '1;
    end else if (baud_tick) begin
      hist_q <= {hist_q[0], rxd_s};
    end
  end

  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_s) | (hist_q[0] & rxd_s);
`else
  assign sample = rxd_s;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      brk_q   <= brk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    brk_d   = brk_q;
    deliver = 1'b0;
    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == MID_START) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = sample ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == MID_BIT) begin
            cnt_d   = '0;
            shreg_d = {sample, shreg_q[DATA_BITS-1:1]};
            if (idx_q == LAST_IDX) begin
              state_d = PARITY;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (cnt_q == MID_BIT) begin
            cnt_d   = '0;
            par_d   = sample;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          // After a low stop bit, park here until the line is seen high again.
          if (brk_q) begin
            if (rxd_s) begin
              brk_d   = 1'b0;
              state_d = IDLE;
            end
          end else if (cnt_q == MID_BIT) begin
            cnt_d   = '0;
            deliver = 1'b1;
            if (sample) begin
              state_d = IDLE;
            end else begin
              brk_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RX_Data       <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_valid      <= deliver;
      parity_error  <= deliver & (par_q ^ parity_even(PAR_W'(shreg_q)));
      framing_error <= deliver & ~sample;
      if (deliver) begin
        RX_Data <= shreg_q;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: doc/uart_receiver_ash.md
Name: uart_receiver_ash

Overview:
- UART receive stage; consumes the serial line driven by the team's UART transmitter (loopback partner) and recovers parallel bytes.
- Frame format matches the transmitter: 1 start bit (0), DATA_BITS data bits LSB first, 1 even-parity bit, 1 stop bit (1).
- Oversamples RXD on an external baud_tick. Delivers each byte as a one-cycle valid pulse with parity and framing status.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit; power of 2, >=4.
- DATA_BITS, 8, data bits per frame; range 5..8.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- baud_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate.
- RXD  input  1  asynchronous serial line; idles high.
- RX_Data  output  DATA_BITS  last received byte; held until the next completed frame.
- rx_valid  output  1  one-clk pulse per completed frame.
- parity_error  output  1  qualifies rx_valid; 1 = received parity != ^RX_Data.
- framing_error  output  1  qualifies rx_valid; 1 = stop bit sampled as 0.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Input synchronisation: RXD passes through a 2-flop synchroniser (rxd_s); both flops reset to 1.
- Reset values: RX_Data=0, rx_valid=0, parity_error=0, framing_error=0, busy=0. State=IDLE, sample counter=0, bit index=0, shift register=0.
- Reset mid-frame aborts the frame; no rx_valid pulse is produced.
- Counters advance only on cycles with baud_tick=1. With baud_tick=0 all state holds.
- IDLE: on a tick with rxd_s=0, go to START with counter=0.
- START: counter increments per tick. At counter==OVERSAMPLE/2-1 (mid start bit):
  - rxd_s=0: go to DATA, counter=0, bit index=0.
  - rxd_s=1: glitch; return to IDLE, no output.
- DATA: at counter==OVERSAMPLE-1 (mid-bit):
  - Shift the sample in LSB first (shift right, new bit at MSB); counter=0.
  - After the DATA_BITS-th bit go to PARITY; otherwise increment the bit index.
- PARITY: sample at counter==OVERSAMPLE-1 and store the parity bit; go to STOP.
- STOP: sample at counter==OVERSAMPLE-1.
  - Same cycle: RX_Data<=shift register; rx_valid<=1; parity_error<=stored parity ^ (^shift register); framing_error<=~sample.
  - Sample=1: go to IDLE.
  - Sample=0: stay in STOP until a tick sees rxd_s=1, then go to IDLE. This prevents a break condition from retriggering a frame.
- Output timing: rx_valid and the flags are registered and high for exactly one clk, the cycle after the mid-stop sampling tick. Error flags are 0 whenever rx_valid=0.
- Latency: from the RXD falling edge to rx_valid is 2 sync cycles plus (OVERSAMPLE/2 + (DATA_BITS+2)*OVERSAMPLE) ticks plus 1 clk.
- Back-to-back frames: a start edge in the tick immediately after STOP->IDLE is accepted with no gap requirement.
- A frame whose stop bit reads 0 still delivers data, with framing_error=1.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of rxd_s on the three ticks ending at the sample point (counter values sample-2, sample-1, sample). This applies to the START check as well.
- Undefined: single sample at the sample point.
- Port list and timing are identical in both builds.

Decomposition:
- Shared package uart_pkg:
  - State encoding IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (3 bits), shared with the transmitter.
  - Default constants OVERSAMPLE=16 and DATA_BITS=8.
  - Parity function (even parity via XOR-reduce).
- One sub-module: uart_sync2, a 2-flop synchroniser with reset value parameter RESET_VAL=1.

Test Plan:
- 0xA5 sent at 16 ticks/bit with correct parity 0 -> one rx_valid pulse, RX_Data=0xA5, parity_error=0, framing_error=0, busy low afterwards.
- 0x3C sent with parity bit forced to 1 -> RX_Data=0x3C, parity_error=1, framing_error=0.
- 0x81 sent with stop bit forced to 0, line held low 40 ticks, then high -> framing_error=1 once. No second frame is decoded; busy stays high until the line returns high.
- RXD low pulse of 4 ticks, then high -> no rx_valid; busy returns to 0 after the mid-start check.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses, RX_Data=0x00 then 0xFF, no errors.
- reset asserted after data bit 3 of 0x55, released, then 0x12 sent -> no pulse for 0x55; all outputs 0 during reset; 0x12 received cleanly.
- With UART_RX_MAJORITY_EN: a 1-tick glitch at the sample point of data bit 2 of 0x00 -> RX_Data=0x00.
- Without UART_RX_MAJORITY_EN: same stimulus -> RX_Data=0x04 and parity_error=1.
